// File: rtl/ps2_dir_decoder_pkg.sv
// Shared constants for the PS/2 direction decoder: one-hot headings, scan codes,
// prefix-tracking state encoding and small scan-code lookup helpers.
package ps2_dir_decoder_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  function automatic logic [3:0] wasd_dir(input logic [7:0] code);
    case (code)
      SC_W:    wasd_dir = DIR_UP;
      SC_A:    wasd_dir = DIR_LEFT;
      SC_S:    wasd_dir = DIR_DOWN;
      SC_D:    wasd_dir = DIR_RIGHT;
      default: wasd_dir = DIR_NONE;
    endcase
  endfunction

  function automatic logic [3:0] arrow_dir(input logic [7:0] code);
    case (code)
      SC_UP:    arrow_dir = DIR_UP;
      SC_LEFT:  arrow_dir = DIR_LEFT;
      SC_DOWN:  arrow_dir = DIR_DOWN;
      SC_RIGHT: arrow_dir = DIR_RIGHT;
      default:  arrow_dir = DIR_NONE;
    endcase
  endfunction

  // Up/down and left/right sit two bit positions apart, so a 2-bit rotate flips heading.
  function automatic logic [3:0] opposite_dir(input logic [3:0] d);
    opposite_dir = {d[1:0], d[3:2]};
  endfunction

endpackage

// File: rtl/ps2_dir_decoder_rx_frame.sv
// PS/2 frame receiver: synchronizes KB_clk/KB_data, shifts bits on synced falls,
// checks start/stop/odd parity and drops stalled frames via a watchdog.
module ps2_dir_decoder_rx_frame #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       VGA_clk,
  input  logic       reset,
  input  logic       KB_clk,
  input  logic       KB_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic       kb_clk_s1, kb_clk_s2, kb_clk_prev;
  logic       kb_data_s1, kb_data_s2;
  logic       fall;
  logic [3:0] bit_cnt;
  logic [9:0] shreg;
  logic [WD_W-1:0] wd_cnt;
  logic       frame_ok;

  assign fall = kb_clk_prev & ~kb_clk_s2;

  // On the 11th fall the stop bit is still on the synced data line, not in shreg.
  assign frame_ok = ~shreg[0] & kb_data_s2 & (^shreg[9:1]);

  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      kb_clk_s1   <= 1'b1;
      kb_clk_s2   <= 1'b1;
      kb_clk_prev <= 1'b1;
      kb_data_s1  <= 1'b1;
      kb_data_s2  <= 1'b1;
      bit_cnt     <= 4'd0;
      shreg       <= 10'd0;
      wd_cnt      <= '0;
      byte_valid  <= 1'b0;
      rx_byte     <= 8'd0;
      err         <= 1'b0;
    end else begin
      kb_clk_s1   <= KB_clk;
      kb_clk_s2   <= kb_clk_s1;
      kb_clk_prev <= kb_clk_s2;
      kb_data_s1  <= KB_data;
      kb_data_s2  <= kb_data_s1;
      byte_valid  <= 1'b0;
      err         <= 1'b0;
      if (fall) begin
        wd_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (frame_ok) begin
            byte_valid <= 1'b1;
            rx_byte    <= shreg[8:1];
          end else begin
            err <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {kb_data_s2, shreg[9:1]};
        end
      end else if (bit_cnt != 4'd0) begin
        if (wd_cnt == WD_W'(TIMEOUT_CYCLES)) begin
          wd_cnt  <= '0;
          bit_cnt <= 4'd0;
          err     <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_dir_decoder.sv
// PS/2 keyboard to snake heading: tracks E0/F0 prefixes over received bytes and
// maintains the one-hot direction register with optional reversal blocking.
module ps2_dir_decoder
  import ps2_dir_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter bit BLOCK_REVERSE  = 1'b1
) (
  input  logic       VGA_clk,
  input  logic       reset,
  input  logic       KB_clk,
  input  logic       KB_data,
  output logic [3:0] direction,
  output logic       dir_strobe,
  output logic       frame_err
);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       rx_err;
  dec_state_t dec_state, dec_next;
  logic [3:0] req;
  logic       accept;

  ps2_dir_decoder_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .VGA_clk   (VGA_clk),
    .reset     (reset),
    .KB_clk    (KB_clk),
    .KB_data   (KB_data),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .err       (rx_err)
  );

  assign frame_err = rx_err;

  always_comb begin
    dec_next = dec_state;
    req      = DIR_NONE;
    if (byte_valid) begin
      case (dec_state)
        ST_IDLE: begin
          if (rx_byte == SC_EXT)      dec_next = ST_EXT;
          else if (rx_byte == SC_BRK) dec_next = ST_BRK;
          else                        req      = wasd_dir(rx_byte);
        end
        ST_EXT: begin
          if (rx_byte == SC_BRK) begin
            dec_next = ST_EXT_BRK;
          end else begin
            req      = arrow_dir(rx_byte);
            dec_next = ST_IDLE;
          end
        end
        default: dec_next = ST_IDLE;
      endcase
    end
  end

  // Repeats of the current heading and (optionally) direct reversals never strobe.
  assign accept = (req != DIR_NONE) && (req != direction) &&
                  !(BLOCK_REVERSE && (direction != DIR_NONE) && (req == opposite_dir(direction)));

  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      dec_state  <= ST_IDLE;
      direction  <= DIR_NONE;
      dir_strobe <= 1'b0;
    end else begin
      dec_state  <= rx_err ? ST_IDLE : dec_next;
      dir_strobe <= accept;
      if (accept) direction <= req;
    end
  end

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Directed bench for ps2_dir_decoder: bit-bangs PS/2 frames and checks heading,
// strobe and error pulses against hand-computed expectations.
module tb_ps2_dir_decoder;

  logic       VGA_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       KB_clk  = 1'b1;
  logic       KB_data = 1'b1;
  logic [3:0] direction;
  logic       dir_strobe;
  logic       frame_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int strobe_cnt  = 0;
  int err_cnt     = 0;
  int strobe_cyc  = 0;
  int fall_cyc    = 0;

  ps2_dir_decoder dut (
    .VGA_clk   (VGA_clk),
    .reset     (reset),
    .KB_clk    (KB_clk),
    .KB_data   (KB_data),
    .direction (direction),
    .dir_strobe(dir_strobe),
    .frame_err (frame_err)
  );

  // clock / reset
  always #20 VGA_clk = ~VGA_clk;
  always @(posedge VGA_clk) cyc <= cyc + 1;

  // pulse monitor: a pulse longer than one cycle counts more than once
  always @(negedge VGA_clk) begin
    if (dir_strobe) begin
      strobe_cnt = strobe_cnt + 1;
      strobe_cyc = cyc;
    end
    if (frame_err) err_cnt = err_cnt + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par,
                                             input logic bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  // drivers
  task automatic send_bit(input logic b);
    KB_data = b;
    repeat (4) @(negedge VGA_clk);
    KB_clk   = 1'b0;
    fall_cyc = cyc;
    repeat (4) @(negedge VGA_clk);
    KB_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [10:0] f);
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    repeat (12) @(negedge VGA_clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(make_frame(b, 1'b0, 1'b0));
  endtask

  initial begin
    int s0, e0;
    logic [10:0] f;

    // reset state
    repeat (3) @(negedge VGA_clk);
    check("reset_dir", direction, 4'b0000);
    check("reset_strobe", dir_strobe, 0);
    check("reset_err", frame_err, 0);
    check("reset_bitcnt", dut.u_rx.bit_cnt, 0);
    reset = 1'b0;
    repeat (5) @(negedge VGA_clk);

    // 1: W, strobe two synchronizer cycles plus two pipeline cycles after the last KB_clk drop
    send_byte(8'h1D);
    check("t1_dir", direction, 4'b0001);
    check("t1_strobes", strobe_cnt, 1);
    check("t1_latency", strobe_cyc - fall_cyc, 4);
    check("t1_err", err_cnt, 0);

    // 2: extended left, then extended release
    send_byte(8'hE0); send_byte(8'h6B);
    check("t2_dir", direction, 4'b0010);
    check("t2_strobes", strobe_cnt, 2);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    check("t2_rel_dir", direction, 4'b0010);
    check("t2_rel_strobes", strobe_cnt, 2);

    // 3: release of D, reversal D, then S
    send_byte(8'hF0); send_byte(8'h23);
    check("t3_brk_dir", direction, 4'b0010);
    check("t3_brk_strobes", strobe_cnt, 2);
    send_byte(8'h23);
    check("t3_rev_dir", direction, 4'b0010);
    check("t3_rev_strobes", strobe_cnt, 2);
    send_byte(8'h1B);
    check("t3_down_dir", direction, 4'b0100);
    check("t3_down_strobes", strobe_cnt, 3);

    // 4: bad parity, bad stop, then good A and a typematic repeat of it
    send_frame(make_frame(8'h1C, 1'b1, 1'b0));
    check("t4_par_err", err_cnt, 1);
    check("t4_par_dir", direction, 4'b0100);
    send_frame(make_frame(8'h1C, 1'b0, 1'b1));
    check("t4_stop_err", err_cnt, 2);
    check("t4_stop_dir", direction, 4'b0100);
    send_byte(8'h1C);
    check("t4_good_dir", direction, 4'b0010);
    check("t4_good_strobes", strobe_cnt, 4);
    send_byte(8'h1C);
    check("t4_repeat_strobes", strobe_cnt, 4);
    check("t4_total_err", err_cnt, 2);

    // 5: stalled partial frame trips the watchdog only after the timeout
    f = make_frame(8'h1D, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(f[i]);
    check("t5_partial_bitcnt", dut.u_rx.bit_cnt, 5);
    repeat (4900) @(negedge VGA_clk);
    check("t5_early_err", err_cnt, 2);
    repeat (200) @(negedge VGA_clk);
    check("t5_timeout_err", err_cnt, 3);
    check("t5_bitcnt", dut.u_rx.bit_cnt, 0);
    send_byte(8'h1D);
    check("t5_next_dir", direction, 4'b0001);
    check("t5_next_strobes", strobe_cnt, 5);

    // 6: go right, then reset mid-frame
    send_byte(8'h23);
    check("t6_right_dir", direction, 4'b1000);
    check("t6_right_strobes", strobe_cnt, 6);
    for (int i = 0; i < 4; i++) send_bit(f[i]);
    reset = 1'b1;
    #1;
    check("t6_reset_dir", direction, 4'b0000);
    s0 = strobe_cnt;
    e0 = err_cnt;
    repeat (3) @(negedge VGA_clk);
    reset = 1'b0;
    repeat (30) @(negedge VGA_clk);
    check("t6_post_strobes", strobe_cnt, s0);
    check("t6_post_err", err_cnt, e0);
    check("t6_post_bitcnt", dut.u_rx.bit_cnt, 0);
    send_byte(8'h1D);
    check("t6_next_dir", direction, 4'b0001);
    check("t6_next_strobes", strobe_cnt, s0 + 1);
    check("t6_final_err", err_cnt, e0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20ms;
    miscompares++;
    $display("FAIL watchdog: observed timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "time limit");
  end

endmodule
